pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pp_pkg.sv | 7 +
 rtl/branch_target_calc.sv | 12 +
 rtl/pc_fetch.sv | 97 +++++++++
 tb/tb_pc_fetch.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pp_pkg.sv
// pp_pkg: shared widths and fetch FSM state encoding for the pipeline blocks.
package pp_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int DISP_W_DEF = 8;
  localparam int INST_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, REQ, FULL, FLUSH} fetch_state_t;
endpackage

// File: rtl/branch_target_calc.sv
// branch_target_calc: next address = pc + 1, plus sign-extended disp when taken (wraps).
module branch_target_calc #(
  parameter int ADDR_W = 12,
  parameter int DISP_W = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [DISP_W-1:0] disp,
  input  logic              taken,
  output logic [ADDR_W-1:0] next
);
  assign next = pc + ADDR_W'(1) + (taken ? ADDR_W'($signed(disp)) : '0);
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch FSM with registered instruction buffer and branch redirect.
// PC_FETCH_PREFETCH_EN selects a 2-entry buffer; default build uses 1 entry.
module pc_fetch import pp_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DISP_W = DISP_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [DISP_W-1:0] br_disp
);
`ifdef PC_FETCH_PREFETCH_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif
  fetch_state_t state, state_n;
  logic [ADDR_W-1:0] fetch_pc, pc_n, tgt, tgt_n, calc_pc, nxt;
  logic [1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] baddr [2];
  logic [INST_W-1:0] bdata [2];
  logic push, pop, wr_idx;
  // one adder serves both sequential advance and branch target
  assign calc_pc = br_valid ? br_pc : fetch_pc;
  branch_target_calc #(.ADDR_W(ADDR_W), .DISP_W(DISP_W)) u_calc (
    .pc(calc_pc), .disp(br_disp), .taken(br_valid), .next(nxt)
  );
  assign imem_req   = state == REQ || state == FLUSH;
  assign imem_addr  = fetch_pc;
  assign inst_valid = cnt != 2'd0;
  assign inst_data  = bdata[0];
  assign inst_addr  = baddr[0];
  assign push   = state == REQ && imem_ack && !br_valid;
  assign pop    = inst_valid && inst_ready && !br_valid;
  assign cnt_n  = br_valid ? 2'd0 : cnt + {1'b0, push} - {1'b0, pop};
  assign wr_idx = cnt == 2'd2 || (cnt == 2'd1 && !pop);
  always_comb begin
    state_n = state;
    pc_n    = fetch_pc;
    tgt_n   = tgt;
    unique case (state)
      IDLE: begin
        state_n = REQ;
        pc_n    = br_valid ? nxt : fetch_pc;
      end
      REQ: begin
        // a redirect without ack must wait for the in-flight read to retire
        state_n = br_valid && !imem_ack ? FLUSH : (imem_ack && !br_valid && cnt_n == DEPTH) ? FULL : REQ;
        tgt_n   = br_valid && !imem_ack ? nxt : tgt;
        pc_n    = imem_ack || br_valid ? (br_valid && !imem_ack ? fetch_pc : nxt) : fetch_pc;
      end
      FULL: begin
        state_n = br_valid || pop ? REQ : FULL;
        pc_n    = br_valid ? nxt : fetch_pc;
      end
      FLUSH: begin
        tgt_n   = br_valid ? nxt : tgt;
        state_n = imem_ack ? REQ : FLUSH;
        pc_n    = imem_ack ? (br_valid ? nxt : tgt) : fetch_pc;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      tgt      <= RESET_PC;
      cnt      <= 2'd0;
      baddr    <= '{default: '0};
      bdata    <= '{default: '0};
    end else begin
      state    <= state_n;
      fetch_pc <= pc_n;
      tgt      <= tgt_n;
      cnt      <= cnt_n;
      if (pop) begin
        baddr[0] <= baddr[1];
        bdata[0] <= bdata[1];
      end
      if (push) begin
        baddr[wr_idx] <= fetch_pc;
        bdata[wr_idx] <= imem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: self-checking bench for pc_fetch with memory responder and delivery scoreboard.
module tb_pc_fetch;
`ifdef PC_FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  logic clk = 0, rst_n = 1;
  logic imem_req, imem_ack = 0, inst_valid, inst_ready = 0, br_valid = 0;
  logic [11:0] imem_addr, inst_addr, br_pc = 0;
  logic [15:0] imem_rdata = 0, inst_data;
  logic [7:0] br_disp = 0;
  int checks = 0, failures = 0;
  typedef struct {logic [11:0] a; logic [15:0] d;} exp_t;
  typedef struct {bit rdy; logic [11:0] pc; logic [7:0] disp; logic [11:0] exp;} vec_t;
  exp_t q[$];
  vec_t tbl[6];
  logic [11:0] exp_pc = 0, pend = 0;
  bit flushing = 0, idle = 0;

  pc_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_addr(inst_addr),
    .br_valid(br_valid), .br_pc(br_pc), .br_disp(br_disp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [11:0] a);
    return {a[3:0], a} ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // called at a negedge: checks current outputs, drives next-edge inputs, advances the model
  task automatic tick(input bit ack, input bit rdy, input bit br, input logic [11:0] bpc, input logic [7:0] bdisp);
    logic [11:0] t;
    bit exp_req, ack_e;
    exp_t e;
    exp_req = !idle && (q.size() < DEPTH);
    chk("req", imem_req, exp_req);
    if (exp_req) chk("addr", imem_addr, exp_pc);
    chk("valid", inst_valid, q.size() != 0);
    ack_e = ack && exp_req;
    imem_ack = ack && (exp_req || idle);
    imem_rdata = mem(exp_pc);
    inst_ready = rdy;
    br_valid = br;
    br_pc = bpc;
    br_disp = bdisp;
    if (inst_valid && rdy && !br && q.size() != 0) begin
      e = q.pop_front();
      chk("inst_addr", inst_addr, e.a);
      chk("inst_data", inst_data, e.d);
    end
    if (ack_e && !br && !flushing) q.push_back('{exp_pc, mem(exp_pc)});
    t = bpc + 12'd1 + {{4{bdisp[7]}}, bdisp};
    if (br) q.delete();
    if (flushing) begin
      if (ack_e) begin
        exp_pc = br ? t : pend;
        flushing = 0;
      end else if (br) pend = t;
    end else if (br) begin
      if (ack_e || !exp_req) exp_pc = t;
      else begin
        flushing = 1;
        pend = t;
      end
    end else if (ack_e) exp_pc = exp_pc + 12'd1;
    idle = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_valid"}, inst_valid, 0);
    chk({tag, "_data"}, inst_data, 0);
    chk({tag, "_iaddr"}, inst_addr, 0);
  endtask

  task automatic model_reset();
    q.delete();
    exp_pc = 0;
    flushing = 0;
    idle = 1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 12'h010, 8'h05, 12'h016};
    tbl[1] = '{1'b0, 12'h010, 8'h05, 12'h016};
    tbl[2] = '{1'b1, 12'h010, 8'hFB, 12'h00C};
    tbl[3] = '{1'b0, 12'hFF0, 8'h7F, 12'h070};
    tbl[4] = '{1'b1, 12'hFFF, 8'h00, 12'h000};
    tbl[5] = '{1'b0, 12'h800, 8'h80, 12'h781};
    #1 rst_n = 0;
    #1 chk_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    // sequential fetch: addresses 0,1,2 in order
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      while (!imem_req && n < 4) begin
        tick(1, 1, 0, 0, 0);
        n++;
      end
      chk("seq_addr", imem_addr, k);
      tick(1, 1, 0, 0, 0);
    end
    repeat (3) tick(1, 1, 0, 0, 0);
    // branch target vectors, with the buffer either draining or stalled full
    foreach (tbl[i]) begin
      repeat (4) tick(1, tbl[i].rdy, 0, 0, 0);
      tick(1, 1, 1, tbl[i].pc, tbl[i].disp);
      chk("tbl_target", imem_addr, tbl[i].exp);
      chk("tbl_flushed", inst_valid, 0);
      repeat (3) tick(1, 1, 0, 0, 0);
    end
    // redirect while a read is outstanding; ack arrives three cycles later
    tick(1, 1, 1, 12'h01F, 8'h00);
    tick(0, 1, 1, 12'h100, 8'h10);
    chk("hold0", imem_addr, 12'h020);
    tick(0, 1, 0, 0, 0);
    chk("hold1", imem_addr, 12'h020);
    chk("hold_req", imem_req, 1);
    tick(0, 1, 0, 0, 0);
    chk("hold2", imem_addr, 12'h020);
    tick(1, 1, 0, 0, 0);
    chk("flush_tgt", imem_addr, 12'h111);
    chk("flush_discard", inst_valid, 0);
    repeat (3) tick(1, 1, 0, 0, 0);
    // last redirect during the flush wins
    tick(1, 1, 1, 12'h01F, 8'h00);
    tick(0, 1, 1, 12'h300, 8'h00);
    tick(0, 1, 1, 12'h400, 8'h02);
    tick(1, 1, 0, 0, 0);
    chk("last_wins", imem_addr, 12'h403);
    // decoder stall fills the buffer then resumes without loss or duplication
    repeat (10) tick(1, 0, 0, 0, 0);
    chk("stall_req", imem_req, 0);
    chk("stall_full", inst_valid, 1);
    repeat (12) tick(1, 1, 0, 0, 0);
    // reset during a pending request, late ack after release is ignored
    tick(1, 1, 1, 12'h01F, 8'h00);
    tick(0, 1, 0, 0, 0);
    #2 rst_n = 0;
    #1 chk_reset_outputs("mid_rst");
    imem_ack = 0;
    br_valid = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    tick(1, 1, 0, 0, 0);
    chk("first_after_rst", imem_addr, 12'h000);
    chk("late_ack_ignored", inst_valid, 0);
    repeat (6) tick(1, 1, 0, 0, 0);
    repeat (4) tick(0, 1, 0, 0, 0);
    chk("drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
